// File: rtl/ws2812b_anim.sv
// ws2812b_anim: frame-tick driven animation source for a WS2812B serializer.
// On each enabled frame tick it rewrites every LED slot with one of four
// patterns (solid, chase, rainbow, off). Each pattern is scaled by a global
// brightness and emitted in {G,R,B} order.
//
// Write-port handshake: the downstream port has no back-pressure. `write` is
// a one-cycle strobe, and `led_num`/`rgb_data` are valid in exactly the
// cycles where `write`=1. Both hold their last value otherwise.
module ws2812b_anim #(
   parameter int         NUM_LEDS     = 28,
   parameter int         FRAME_CYCLES = 27_000_000 / 60,
   parameter logic [7:0] HUE_STEP     = 8'd9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  mode,
   input  logic [23:0] color,
   input  logic [7:0]  brightness,
   input  logic [7:0]  speed,
   output logic        write,
   output logic [7:0]  led_num,
   output logic [23:0] rgb_data,
   output logic        busy,
   output logic        frame_done
);

   localparam int            CW       = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CW-1:0] TICK_AT  = CW'(FRAME_CYCLES - 1);
   localparam logic [7:0]    LAST_IDX = 8'(NUM_LEDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

   state_t        state;
   logic [CW-1:0] tick_cnt;
   logic          tick;

   // Frame parameters captured at the starting tick
   logic [1:0]  mode_l;
   logic [23:0] color_l;
   logic [7:0]  bright_l;
   logic [7:0]  speed_l;

   // Animation state and the issue stage of the pipeline
   logic [7:0]  phase;
   logic [7:0]  pos;
   logic [7:0]  idx;
   logic        issue;

   // Combinational color path between the issue stage and the output stage
   logic [15:0] hue_mul;
   logic [7:0]  hue;
   logic [7:0]  wk;
   logic [7:0]  wk3;
   logic [7:0]  wr;
   logic [7:0]  wg;
   logic [7:0]  wb;
   logic [23:0] base;
   logic [23:0] scaled;

   // Channel scale: (c * (b + 1)) >> 8, so b=255 is identity and b=0 is black
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] p;
      p = {8'd0, c} * ({8'd0, b} + 16'd1);
      return p[15:8];
   endfunction

   assign tick = (tick_cnt == TICK_AT);

   // Free-running frame tick counter, independent of enable and FSM state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Color wheel, pattern select and brightness scaling for the issued index
   always_comb begin
      hue_mul = {8'd0, idx} * {8'd0, HUE_STEP};
      hue     = phase + hue_mul[7:0];
      wk      = 8'd0;
      wk3     = 8'd0;
      wr      = 8'd0;
      wg      = 8'd0;
      wb      = 8'd0;
      if (hue < 8'd85) begin
         wk  = hue;
         wk3 = (wk << 1) + wk;
         wr  = 8'd255 - wk3;
         wg  = wk3;
      end else if (hue < 8'd170) begin
         wk  = hue - 8'd85;
         wk3 = (wk << 1) + wk;
         wg  = 8'd255 - wk3;
         wb  = wk3;
      end else begin
         wk  = hue - 8'd170;
         wk3 = (wk << 1) + wk;
         wr  = wk3;
         wb  = 8'd255 - wk3;
      end
      case (mode_l)
         2'd0:    base = color_l;
         2'd1:    base = (idx == pos) ? color_l : 24'd0;
         2'd2:    base = {wg, wr, wb};
         default: base = 24'd0;
      endcase
      scaled = {scale(base[23:16], bright_l),
                scale(base[15:8],  bright_l),
                scale(base[7:0],   bright_l)};
   end

   // Frame FSM: latch on tick, issue indices, drain the pipeline, then advance the animation
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         idx        <= 8'd0;
         issue      <= 1'b0;
         mode_l     <= 2'd0;
         color_l    <= 24'd0;
         bright_l   <= 8'd0;
         speed_l    <= 8'd0;
         phase      <= 8'd0;
         pos        <= 8'd0;
         write      <= 1'b0;
         led_num    <= 8'd0;
         rgb_data   <= 24'd0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         write      <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tick && enable) begin
                  state    <= S_WRITE;
                  idx      <= 8'd0;
                  issue    <= 1'b1;
                  busy     <= 1'b1;
                  mode_l   <= mode;
                  color_l  <= color;
                  bright_l <= brightness;
                  speed_l  <= speed;
               end
            end
            S_WRITE: begin
               if (issue) begin
                  write    <= 1'b1;
                  led_num  <= idx;
                  rgb_data <= scaled;
                  if (idx == LAST_IDX) begin
                     issue <= 1'b0;
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end else begin
                  // Last write is on the port this cycle; next cycle is DONE
                  state      <= S_DONE;
                  frame_done <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               phase <= phase + speed_l;
               pos   <= (pos == LAST_IDX) ? 8'd0 : pos + 8'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
